// File: rtl/serial_job_ctrl.sv
// serial_job_ctrl: front-end for the solver core.
// Receives framed bytes on data_in (start bit 1, then 8 data bits LSB first) and
// hands them to the core through a one-entry hold register. A byte equal to
// EOT_BYTE closes the job. The controller then waits for the core's result and
// sends it on data_out (start bit 1, then RESULT_W bits LSB first).
//
// Byte stream handshake: byte_valid rises the cycle after a byte completes.
// While byte_valid is high, byte_data and byte_last hold steady until a rising
// edge with byte_valid && byte_ready, which transfers the beat.
module serial_job_ctrl #(
  parameter int          RESULT_W = 64,
  parameter logic [7:0]  EOT_BYTE = 8'h04
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                data_in,
  output logic                data_out,
  output logic [7:0]          byte_data,
  output logic                byte_valid,
  input  logic                byte_ready,
  output logic                byte_last,
  input  logic [RESULT_W-1:0] result,
  input  logic                result_valid,
  output logic                busy,
  output logic                overrun
);

  localparam int                    TX_CNT_W = $clog2(RESULT_W + 1);
  localparam logic [TX_CNT_W-1:0]   TX_LAST  = TX_CNT_W'(RESULT_W);
  localparam logic [TX_CNT_W-1:0]   TX_ONE   = TX_CNT_W'(1);

  typedef enum logic [1:0] {
    ST_RX       = 2'd0,
    ST_WAIT_RES = 2'd1,
    ST_TX       = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  rx_shift_q, rx_shift_d;   // 0 = IDLE, 1 = SHIFT
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [6:0]            sh_q, sh_d;               // bits 0..6 of the frame in flight
  logic [7:0]            hold_data_q, hold_data_d;
  logic                  hold_valid_q, hold_valid_d;
  logic                  hold_last_q, hold_last_d;
  logic                  rx_stop_q, rx_stop_d;     // EOT loaded: ignore further start bits
  logic                  busy_q, busy_d;
  logic                  overrun_q, overrun_d;
  logic [RESULT_W-1:0]   tx_sh_q, tx_sh_d;
  logic [TX_CNT_W-1:0]   tx_cnt_q, tx_cnt_d;
  logic                  dout_q, dout_d;

  logic                  handshake;
  logic                  rx_done;
  logic [7:0]            rx_byte;

  assign handshake = hold_valid_q && byte_ready;

  // Next-state logic: receiver, hold register and transmitter sequencing.
  always_comb begin
    state_d      = state_q;
    rx_shift_d   = rx_shift_q;
    bit_cnt_d    = bit_cnt_q;
    sh_d         = sh_q;
    hold_data_d  = hold_data_q;
    hold_valid_d = hold_valid_q;
    hold_last_d  = hold_last_q;
    rx_stop_d    = rx_stop_q;
    busy_d       = busy_q;
    overrun_d    = overrun_q;
    tx_sh_d      = tx_sh_q;
    tx_cnt_d     = tx_cnt_q;
    dout_d       = 1'b0;
    rx_done      = 1'b0;
    rx_byte      = {data_in, sh_q};

    case (state_q)
      ST_RX: begin
        if (!rx_shift_q) begin
          if (!rx_stop_q && data_in) begin
            rx_shift_d = 1'b1;
            bit_cnt_d  = 3'd0;
            busy_d     = 1'b1;
          end
        end else begin
          sh_d = {data_in, sh_q[6:1]};
          if (bit_cnt_q == 3'd7) begin
            rx_shift_d = 1'b0;
            bit_cnt_d  = 3'd0;
            rx_done    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end

        // A beat leaving the hold register frees it for a byte completing on the same edge.
        if (handshake) begin
          hold_valid_d = 1'b0;
          hold_last_d  = 1'b0;
          if (hold_last_q) begin
            state_d   = ST_WAIT_RES;
            rx_stop_d = 1'b0;
          end
        end

        if (rx_done) begin
          if (hold_valid_q && !handshake) begin
            overrun_d = 1'b1;
          end else begin
            hold_data_d  = rx_byte;
            hold_valid_d = 1'b1;
            hold_last_d  = (rx_byte == EOT_BYTE);
            if (rx_byte == EOT_BYTE) begin
              rx_stop_d = 1'b1;
            end
          end
        end
      end

      ST_WAIT_RES: begin
        if (result_valid) begin
          tx_sh_d  = result;
          tx_cnt_d = '0;
          dout_d   = 1'b1;
          state_d  = ST_TX;
        end
      end

      ST_TX: begin
        if (tx_cnt_q == TX_LAST) begin
          dout_d  = 1'b0;
          busy_d  = 1'b0;
          state_d = ST_RX;
        end else begin
          dout_d   = tx_sh_q[0];
          tx_sh_d  = tx_sh_q >> 1;
          tx_cnt_d = tx_cnt_q + TX_ONE;
        end
      end

      default: begin
        state_d = ST_RX;
      end
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RX;
      rx_shift_q   <= 1'b0;
      bit_cnt_q    <= 3'd0;
      sh_q         <= '0;
      hold_data_q  <= 8'h00;
      hold_valid_q <= 1'b0;
      hold_last_q  <= 1'b0;
      rx_stop_q    <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      tx_sh_q      <= '0;
      tx_cnt_q     <= '0;
      dout_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_shift_q   <= rx_shift_d;
      bit_cnt_q    <= bit_cnt_d;
      sh_q         <= sh_d;
      hold_data_q  <= hold_data_d;
      hold_valid_q <= hold_valid_d;
      hold_last_q  <= hold_last_d;
      rx_stop_q    <= rx_stop_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
      tx_sh_q      <= tx_sh_d;
      tx_cnt_q     <= tx_cnt_d;
      dout_q       <= dout_d;
    end
  end

  assign data_out   = dout_q;
  assign byte_data  = hold_data_q;
  assign byte_valid = hold_valid_q;
  assign byte_last  = hold_last_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_serial_job_ctrl.sv
// Bench for serial_job_ctrl: directed scenarios followed by randomized jobs,
// with a cycle-level reference model that predicts every output each cycle.
module tb_serial_job_ctrl;

  localparam int         RW  = 64;
  localparam logic [7:0] EOT = 8'h04;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          data_in = 1'b0;
  logic          byte_ready = 1'b0;
  logic          result_valid = 1'b0;
  logic [RW-1:0] result = '0;
  logic          data_out;
  logic [7:0]    byte_data;
  logic          byte_valid;
  logic          byte_last;
  logic          busy;
  logic          overrun;

  always #5 clk = ~clk;

  serial_job_ctrl #(.RESULT_W(RW), .EOT_BYTE(EOT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .data_out     (data_out),
    .byte_data    (byte_data),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .byte_last    (byte_last),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phases: 0 = receiving, 1 = waiting for result, 2 = sending result.
  // exp_q holds the byte waiting for the core as {last, data}; at most one entry.
  int            m_phase = 0;
  int            m_pos = -1;         // -1 idle, else index of next data bit
  logic [7:0]    m_acc = '0;
  logic          m_stop = 1'b0;
  logic          m_busy = 1'b0;
  logic          m_ovr = 1'b0;
  logic          m_dout = 1'b0;
  logic [RW-1:0] m_res = '0;
  int            m_cyc = 0;
  int            m_t0 = 0;
  logic [8:0]    exp_q[$];

  task automatic m_reset();
    m_phase = 0; m_pos = -1; m_acc = '0; m_stop = 1'b0; m_busy = 1'b0;
    m_ovr = 1'b0; m_dout = 1'b0; m_res = '0;
    exp_q.delete();
  endtask

  task automatic m_step();
    logic       done;
    logic       hs;
    logic [8:0] head;
    int         k;
    m_cyc++;
    done = 1'b0;
    hs = (exp_q.size() != 0) && byte_ready;
    case (m_phase)
      0: begin
        if (m_pos < 0) begin
          if (!m_stop && data_in) begin
            m_pos = 0;
            m_busy = 1'b1;
          end
        end else begin
          m_acc[m_pos] = data_in;
          if (m_pos == 7) begin
            done = 1'b1;
            m_pos = -1;
          end else begin
            m_pos++;
          end
        end
        if (hs) begin
          head = exp_q.pop_front();
          if (head[8]) begin
            m_phase = 1;
            m_stop = 1'b0;
          end
        end
        if (done) begin
          if (exp_q.size() != 0) m_ovr = 1'b1;
          else begin
            exp_q.push_back({m_acc == EOT, m_acc});
            if (m_acc == EOT) m_stop = 1'b1;
          end
        end
      end
      1: begin
        if (result_valid) begin
          m_res = result;
          m_t0 = m_cyc;
          m_dout = 1'b1;
          m_phase = 2;
        end
      end
      default: begin
        // k-th edge after the result edge carries result bit k-1; edge RW+1 ends the job.
        k = m_cyc - m_t0;
        if (k <= RW) m_dout = m_res[k-1];
        else begin
          m_dout = 1'b0;
          m_busy = 1'b0;
          m_phase = 0;
        end
      end
    endcase
  endtask

  // Model advances on the same edges as the DUT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_reset();
    else m_step();
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("byte_valid", byte_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      check("byte_data", byte_data, exp_q[0][7:0]);
      check("byte_last", byte_last, exp_q[0][8]);
    end else begin
      check("byte_last_idle", byte_last, 0);
    end
    check("busy", busy, m_busy);
    check("overrun", overrun, m_ovr);
    check("data_out", data_out, m_dout);
  end

  // ---------------- driver tasks ----------------
  logic rand_ready = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
    result_valid = 1'b0;
    if (rand_ready) byte_ready = ($urandom_range(0, 1) == 1);
  endtask

  task automatic idle(input int n);
    data_in = 1'b0;
    repeat (n) tick();
  endtask

  // Drives start bit then 8 data bits; optionally raises ready for the completing edge.
  task automatic send_frame(input logic [7:0] b, input bit ready_on_last);
    for (int i = 0; i < 9; i++) begin
      data_in = (i == 0) ? 1'b1 : b[i-1];
      if (ready_on_last && i == 8) byte_ready = 1'b1;
      tick();
    end
    data_in = 1'b0;
  endtask

  task automatic pulse_result(input logic [RW-1:0] r);
    result = r;
    result_valid = 1'b1;
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_phase(input int ph, input int budget, input string tag);
    bit ok;
    ok = 1'b0;
    for (int w = 0; w < budget; w++) begin
      if (m_phase == ph) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check(tag, ok, 1);
  endtask

  // ---------------- stimulus ----------------
  logic [RW-1:0] res_word;
  logic [7:0]    b;

  initial begin
    res_word = 64'h0123_4567_89AB_CDEF;

    // Reset values
    repeat (3) tick();
    check("rst_data_out", data_out, 0);
    check("rst_byte_data", byte_data, 0);
    check("rst_byte_valid", byte_valid, 0);
    check("rst_byte_last", byte_last, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    tick();

    // Single byte
    byte_ready = 1'b1;
    send_frame(8'h41, 1'b0);
    check("t1_valid", byte_valid, 1);
    check("t1_data", byte_data, 8'h41);
    check("t1_last", byte_last, 0);
    check("t1_busy", busy, 1);
    check("t1_overrun", overrun, 0);
    tick();
    check("t1_valid_pulse", byte_valid, 0);

    // Backpressure and overrun
    byte_ready = 1'b0;
    send_frame(8'h11, 1'b0);
    send_frame(8'h22, 1'b0);
    check("t2_valid", byte_valid, 1);
    check("t2_data_held", byte_data, 8'h11);
    check("t2_overrun", overrun, 1);
    byte_ready = 1'b1;
    tick();
    check("t2_valid_after_accept", byte_valid, 0);
    idle(3);
    check("t2_dropped_never_seen", byte_valid, 0);
    do_reset();
    check("t2_overrun_cleared", overrun, 0);

    // Handshake on the same edge as completion
    byte_ready = 1'b0;
    send_frame(8'h55, 1'b0);
    send_frame(8'h33, 1'b1);
    check("t3_valid", byte_valid, 1);
    check("t3_data", byte_data, 8'h33);
    check("t3_overrun", overrun, 0);
    tick();
    check("t3_accepted", byte_valid, 0);
    do_reset();

    // Full job
    byte_ready = 1'b1;
    send_frame(8'h31, 1'b0);
    check("t4_b0", byte_data, 8'h31);
    idle(1);
    send_frame(8'h32, 1'b0);
    check("t4_b1", byte_data, 8'h32);
    check("t4_b1_last", byte_last, 0);
    idle(1);
    send_frame(EOT, 1'b0);
    check("t4_eot_data", byte_data, EOT);
    check("t4_eot_last", byte_last, 1);
    tick();
    idle(2);
    check("t4_wait_dout", data_out, 0);
    pulse_result(res_word);
    check("t4_start_bit", data_out, 1);
    for (int k = 0; k < RW; k++) begin
      tick();
      check("t4_result_bit", data_out, res_word[k]);
    end
    tick();
    check("t4_end_dout", data_out, 0);
    check("t4_end_busy", busy, 0);

    // Spurious result while receiving; start bit while waiting for result
    pulse_result(64'hFFFF_0000_FFFF_0000);
    check("t5_no_tx", data_out, 0);
    idle(3);
    check("t5_no_tx_later", data_out, 0);
    send_frame(EOT, 1'b0);
    tick();
    send_frame(8'h41, 1'b0);
    check("t5_ignored_in_wait", byte_valid, 0);
    check("t5_busy", busy, 1);
    pulse_result(64'h5);
    idle(RW + 2);
    check("t5_done", busy, 0);

    // Reset during transmission
    send_frame(EOT, 1'b0);
    tick();
    pulse_result({RW{1'b1}});
    repeat (21) tick();
    check("t6_bit20", data_out, 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_dout", data_out, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_valid", byte_valid, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    byte_ready = 1'b1;
    send_frame(8'h41, 1'b0);
    check("t6_after_valid", byte_valid, 1);
    check("t6_after_data", byte_data, 8'h41);
    check("t6_after_last", byte_last, 0);
    tick();
    do_reset();

    // Randomized jobs
    for (int job = 0; job < 15; job++) begin
      rand_ready = 1'b1;
      if ($urandom_range(0, 1) == 1) pulse_result({$urandom, $urandom});
      for (int n = $urandom_range(1, 4); n > 0; n--) begin
        b = 8'($urandom_range(0, 255));
        if (b == EOT) b = 8'h05;
        send_frame(b, 1'b0);
        idle($urandom_range(0, 2));
      end
      rand_ready = 1'b0;
      byte_ready = 1'b1;
      for (int w = 0; w < 20 && exp_q.size() != 0; w++) tick();
      send_frame(EOT, 1'b0);
      wait_phase(1, 20, "rnd_reach_wait");
      repeat ($urandom_range(0, 10)) begin
        data_in = ($urandom_range(0, 1) == 1);
        tick();
      end
      pulse_result({$urandom, $urandom});
      data_in = 1'b0;
      wait_phase(0, RW + 10, "rnd_tx_done");
      idle(2);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #2_000_000;
    n_errors++;
    $display("FAIL global_timeout got=running exp=finished");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_job_ctrl.md
Name: serial_job_ctrl

Overview:
- Front-end controller for the solver datapath behind the single-bit `data_in`/`data_out` pins of `digital_top`.
- Deserializes framed bytes from `data_in` and hands them to the solver core over a valid/ready byte stream.
- Marks end-of-input, waits for the core's result, then serializes the result back out on `data_out`.
- Sequences one job per input stream, then rearms for the next.

Parameters:
- RESULT_W, 64: width of solver result word, serialized LSB first.
- EOT_BYTE, 8'h04: byte value marking end of input; delivered to core with byte_last=1.

Ports:
- clk  in  1  single system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset; clears all state immediately.
- data_in  in  1  serial input; idle 0; frame = start bit 1 then 8 data bits LSB first, one bit per clock.
- data_out  out  1  serial output; idle 0; frame = start bit 1 then RESULT_W bits LSB first.
- byte_data  out  8  received byte to core.
- byte_valid  out  1  byte_data valid; held until accepted.
- byte_ready  in  1  core accepts byte when byte_valid&&byte_ready at a rising edge.
- byte_last  out  1  qualifies byte_valid; 1 only for the EOT_BYTE beat.
- result  in  RESULT_W  solver result.
- result_valid  in  1  one-cycle pulse; result valid this cycle.
- busy  out  1  1 from first start bit until last result bit transmitted.
- overrun  out  1  sticky; set when a byte is dropped; cleared only by reset.

Behaviour:
- Reset values: data_out=0, byte_data=0, byte_valid=0, byte_last=0, busy=0, overrun=0; FSM=RX; rx bit counter=0; hold register empty.
- Main FSM states: RX, WAIT_RES, TX.
- RX state, receiver sub-state IDLE/SHIFT:
  - IDLE: data_in sampled 1 → SHIFT, bit count 0, busy←1.
  - SHIFT: next 8 edges sample bits 0..7 into the shift register.
  - On the edge sampling bit 7, the byte moves to the hold register and the receiver returns to IDLE. byte_valid is high the following cycle.
  - A new start bit is accepted on the edge immediately after bit 7; back-to-back frames are legal.
- Hold register: one entry.
  - Cleared on handshake.
  - If a byte completes while the hold register is still full, the new byte is dropped and overrun←1. Hold contents stay unchanged and valid stays asserted.
  - Handshake and completion on the same edge: the new byte is loaded and no overrun occurs.
- byte_data and byte_last are stable while byte_valid=1 and ready=0.
- EOT handling:
  - A completed byte equal to EOT_BYTE is loaded with byte_last=1.
  - Receiver stops accepting start bits (data_in ignored) from that edge onward.
  - When the EOT beat handshakes, FSM → WAIT_RES.
  - Bytes received before the EOT are delivered normally.
- WAIT_RES:
  - data_in ignored.
  - On result_valid=1: latch result into the TX shift register, FSM → TX.
  - result_valid in RX or TX is ignored; no latch, no error.
- TX:
  - data_out=1 for one cycle (start bit), starting the cycle after the result_valid edge.
  - Then RESULT_W cycles of bits 0..RESULT_W-1.
  - After the last bit: data_out=0, busy=0, FSM → RX with receiver IDLE.
  - Total TX length RESULT_W+1 cycles.
  - data_in ignored during TX; the first new start bit is accepted the cycle busy falls.
- data_out is registered (no combinational path from any input); it is 0 in all states outside TX.
- Reset asserted mid-operation (any state): all outputs return to reset values asynchronously. Any partial frame, held byte or TX result is discarded. After reset release, the block waits for a start bit.
- Counters:
  - rx bit counter 3 bits, no wrap beyond 7.
  - tx counter sized clog2(RESULT_W+1); never wraps.

Test Plan:
- Single byte: after reset, drive 1 then bits of 0x41 LSB first, byte_ready=1 → byte_valid pulses 1 cycle, byte_data=0x41, byte_last=0, busy=1, overrun=0.
- Backpressure/overrun: byte_ready=0, send 0x11 then 0x22 back-to-back → byte_data holds 0x11 with valid high, overrun=1 after second frame. Raise ready → 0x11 accepted, 0x22 never appears.
- Simultaneous handshake: ready asserted exactly on the edge completing second byte 0x33 → 0x33 delivered next cycle, overrun stays 0.
- Full job: send 0x31,0x32 then 0x04 → three beats, third with byte_last=1. Then result=64'h0123_4567_89AB_CDEF with result_valid pulse → data_out: 1, then 0xEF bits LSB first …, 65 cycles, then 0 and busy=0.
- Spurious result: result_valid pulse while in RX → no TX, data_out stays 0. Data_in start bit during WAIT_RES → no byte_valid.
- Reset mid-TX: assert rst_n=0 at result bit 20 → data_out=0, busy=0 immediately. After release, a new 0x41 frame is received correctly.
